// File: rtl/rggen_apb_multi_bridge.sv
// rggen_apb_multi_bridge
//   Bridges a simple valid/ready register bus onto an APB master port that
//   fans out to SLAVES APB slaves. Each slave owns a 2**SLAVE_ADDRESS_WIDTH
//   byte window. The slave index is taken from the address bits directly above
//   that window. An index that has no slave gets a DECERR response without
//   any APB traffic.
//   Ports:
//     i_clk / i_rst_n        clock, asynchronous active-low reset
//     i_bus_*                request side (valid held until o_bus_ready)
//     o_bus_ready/_status/_read_data   one-cycle response strobe + payload
//     o_psel..o_pwdata       registered APB request, shared by all slaves
//     i_pready/_prdata/_pslverr        per-slave APB responses
module rggen_apb_multi_bridge #(
  parameter int         ADDRESS_WIDTH       = 8,
  parameter int         BUS_WIDTH           = 32,
  parameter int         SLAVES              = 2,
  parameter int         SLAVE_ADDRESS_WIDTH = 6,
  parameter int         TIMEOUT             = 0,
  parameter logic [2:0] PPROT               = 3'b000
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_bus_valid,
  input  logic [1:0]                     i_bus_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_bus_address,
  input  logic [BUS_WIDTH-1:0]           i_bus_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_bus_strobe,
  output logic                           o_bus_ready,
  output logic [1:0]                     o_bus_status,
  output logic [BUS_WIDTH-1:0]           o_bus_read_data,
  output logic [SLAVES-1:0]              o_psel,
  output logic                           o_penable,
  output logic [ADDRESS_WIDTH-1:0]       o_paddr,
  output logic [2:0]                     o_pprot,
  output logic                           o_pwrite,
  output logic [BUS_WIDTH/8-1:0]         o_pstrb,
  output logic [BUS_WIDTH-1:0]           o_pwdata,
  input  logic [SLAVES-1:0]              i_pready,
  input  logic [SLAVES*BUS_WIDTH-1:0]    i_prdata,
  input  logic [SLAVES-1:0]              i_pslverr
);

  localparam int STRB_W  = BUS_WIDTH / 8;
  // At least one bit so the index register is always legal. With a single
  // slave it is tied to zero.
  localparam int IDX_W   = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [IDX_W:0] SLAVES_V = (IDX_W+1)'(SLAVES);

  localparam logic [1:0] ST_OKAY   = 2'b00;
  localparam logic [1:0] ST_SLVERR = 2'b10;
  localparam logic [1:0] ST_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPOND} state_e;

  state_e                    state_q,   state_d;
  logic [SLAVES-1:0]         psel_q,    psel_d;
  logic                      penable_q, penable_d;
  logic [ADDRESS_WIDTH-1:0]  paddr_q,   paddr_d;
  logic                      pwrite_q,  pwrite_d;
  logic [STRB_W-1:0]         pstrb_q,   pstrb_d;
  logic [BUS_WIDTH-1:0]      pwdata_q,  pwdata_d;
  logic [IDX_W-1:0]          idx_q,     idx_d;
  logic [CNT_W-1:0]          cnt_q,     cnt_d;
  logic                      ready_q,   ready_d;
  logic [1:0]                status_q,  status_d;
  logic [BUS_WIDTH-1:0]      rdata_q,   rdata_d;

  // Only bit 0 of the access type matters to APB.
  logic unused_access;
  assign unused_access = i_bus_access[1];

  // Request decode.
  logic [IDX_W-1:0] req_idx;
  logic             req_hit;

  generate
    if (SLAVES == 1) begin : g_single
      assign req_idx = '0;
      assign req_hit = 1'b1;
    end else begin : g_multi
      assign req_idx = i_bus_address[SLAVE_ADDRESS_WIDTH +: IDX_W];
      assign req_hit = ({1'b0, req_idx} < SLAVES_V);
    end
  endgenerate

  // Response mux. Only the latched slave is looked at, so other slaves'
  // handshake lines cannot disturb the transfer.
  logic                 sel_ready;
  logic                 sel_err;
  logic [BUS_WIDTH-1:0] sel_rdata;

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < SLAVES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ready = i_pready[k];
        sel_err   = i_pslverr[k];
        sel_rdata = i_prdata[k*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // The timeout fires on the last allowed ACCESS cycle. It is only checked
  // after pready, so a late ready still completes normally.
  logic timeout_hit;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_W'(TO_LAST));

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pstrb_d   = pstrb_q;
    pwdata_d  = pwdata_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    status_d  = status_q;
    rdata_d   = rdata_q;

    case (state_q)
      IDLE: begin
        if (i_bus_valid) begin
          paddr_d  = i_bus_address;
          pwrite_d = i_bus_access[0];
          pstrb_d  = i_bus_access[0] ? i_bus_strobe : '0;
          pwdata_d = i_bus_write_data;
          idx_d    = req_idx;
          if (req_hit) begin
            state_d = SETUP;
            for (int k = 0; k < SLAVES; k++) begin
              psel_d[k] = (req_idx == IDX_W'(k));
            end
          end else begin
            state_d  = RESPOND;
            ready_d  = 1'b1;
            status_d = ST_DECERR;
            rdata_d  = '0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        if (sel_ready) begin
          state_d   = RESPOND;
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          status_d  = sel_err ? ST_SLVERR : ST_OKAY;
          rdata_d   = pwrite_q ? '0 : sel_rdata;
        end else if (timeout_hit) begin
          state_d   = RESPOND;
          psel_d    = '0;
          penable_d = 1'b0;
          ready_d   = 1'b1;
          status_d  = ST_SLVERR;
          rdata_d   = '0;
        end else if (TIMEOUT > 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESPOND: begin
        // A valid request seen here is left alone. It is picked up once the
        // FSM is back in IDLE.
        state_d  = IDLE;
        status_d = ST_OKAY;
        rdata_d  = '0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pstrb_q   <= '0;
      pwdata_q  <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      status_q  <= ST_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pstrb_q   <= pstrb_d;
      pwdata_q  <= pwdata_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
    end
  end

  assign o_bus_ready     = ready_q;
  assign o_bus_status    = status_q;
  assign o_bus_read_data = rdata_q;
  assign o_psel          = psel_q;
  assign o_penable       = penable_q;
  assign o_paddr         = paddr_q;
  assign o_pprot         = PPROT;
  assign o_pwrite        = pwrite_q;
  assign o_pstrb         = pstrb_q;
  assign o_pwdata        = pwdata_q;

endmodule

// File: tb/tb_rggen_apb_multi_bridge.sv
// Testbench for rggen_apb_multi_bridge: SLAVES=3, TIMEOUT=4, 64-byte windows.
// Slave models hold pready low for a configurable number of ACCESS cycles.
// Unselected slaves drive pready=1, pslverr=1 and junk data, so any leak of
// their lines into the response shows up as a mismatch.
module tb_rggen_apb_multi_bridge;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bus_valid = 1'b0;
  logic [1:0]    bus_access = 2'b00;
  logic [AW-1:0] bus_addr = '0;
  logic [DW-1:0] bus_wdata = '0;
  logic [3:0]    bus_strb = '0;
  logic          bus_ready;
  logic [1:0]    bus_status;
  logic [DW-1:0] bus_rdata;
  logic [NS-1:0] psel;
  logic          penable;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic          pwrite;
  logic [3:0]    pstrb;
  logic [DW-1:0] pwdata;
  logic [NS-1:0] pready;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0] pslverr;

  always #5 clk = ~clk;

  rggen_apb_multi_bridge #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .SLAVES(NS),
    .SLAVE_ADDRESS_WIDTH(6), .TIMEOUT(TO), .PPROT(3'b010)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_bus_valid(bus_valid), .i_bus_access(bus_access),
    .i_bus_address(bus_addr), .i_bus_write_data(bus_wdata),
    .i_bus_strobe(bus_strb),
    .o_bus_ready(bus_ready), .o_bus_status(bus_status),
    .o_bus_read_data(bus_rdata),
    .o_psel(psel), .o_penable(penable), .o_paddr(paddr), .o_pprot(pprot),
    .o_pwrite(pwrite), .o_pstrb(pstrb), .o_pwdata(pwdata),
    .i_pready(pready), .i_prdata(prdata), .i_pslverr(pslverr)
  );

  // Slave models
  int            wait_cyc [NS];
  logic          err_cfg  [NS];
  logic [DW-1:0] rd_cfg   [NS];
  int            acnt     [NS];

  initial begin
    for (int k = 0; k < NS; k++) begin
      wait_cyc[k] = 0; err_cfg[k] = 1'b0; rd_cfg[k] = '0; acnt[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NS; k++)
      acnt[k] <= (psel[k] && penable) ? acnt[k] + 1 : 0;
  end

  for (genvar k = 0; k < NS; k++) begin : g_slv
    assign pready[k]          = (psel[k] && penable) ? (acnt[k] >= wait_cyc[k]) : 1'b1;
    assign pslverr[k]         = psel[k] ? err_cfg[k] : 1'b1;
    assign prdata[k*DW +: DW] = psel[k] ? rd_cfg[k] : 32'hDEADBEEF;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the outcome follows from the address window and the
  // slave's wait count alone.
  task automatic model(input logic [AW-1:0] addr, input logic wr, input int wt,
                       input logic err, input logic [DW-1:0] rd,
                       output int lat, output logic [1:0] st,
                       output logic [DW-1:0] data, output int pcyc);
    int idx;
    idx = int'(addr) / 64;
    if (idx >= NS) begin
      lat = 1; st = 2'b11; data = '0; pcyc = 0;
    end else if (wt >= TO) begin
      lat = TO + 2; st = 2'b10; data = '0; pcyc = TO + 1;
    end else begin
      lat = wt + 3; st = err ? 2'b10 : 2'b00; data = wr ? '0 : rd; pcyc = wt + 2;
    end
  endtask

  // Drive one request and watch it. Latency k means ready is seen on the
  // falling edge after rising edge N+k-1, where edge N samples the request.
  task automatic do_txn(input logic [AW-1:0] addr, input logic wr,
                        input logic [DW-1:0] wd, input logic [3:0] sb,
                        input logic hold,
                        output int lat, output logic [1:0] st,
                        output logic [DW-1:0] data, output int pcyc);
    logic [NS-1:0] exp_sel;
    int idx;
    bit got;
    idx = int'(addr) / 64;
    exp_sel = '0;
    if (idx < NS) exp_sel[idx] = 1'b1;
    lat = -1; st = 2'bxx; data = 'x; pcyc = 0; got = 0;
    bus_valid = 1'b1; bus_access = {1'b0, wr}; bus_addr = addr;
    bus_wdata = wd; bus_strb = sb;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("psel_onehot", 64'($countones(psel) <= 1), 64'd1);
      if (psel != '0) begin
        check("psel_idx", 64'(psel), 64'(exp_sel));
        check("penable_phase", 64'(penable), (pcyc == 0) ? 64'd0 : 64'd1);
        check("paddr_stable", 64'(paddr), 64'(addr));
        check("pwrite_stable", 64'(pwrite), 64'(wr));
        check("pstrb_stable", 64'(pstrb), wr ? 64'(sb) : 64'd0);
        if (wr) check("pwdata_stable", 64'(pwdata), 64'(wd));
        pcyc++;
      end
      if (bus_ready) begin
        check("psel_in_respond", 64'(psel), 64'd0);
        lat = i + 1; st = bus_status; data = bus_rdata; got = 1;
        if (!hold) bus_valid = 1'b0;
        break;
      end else begin
        check("rdata_idle_zero", 64'(bus_rdata), 64'd0);
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: addr %0h got no ready within 40 cycles", addr);
    end else if (!hold) begin
      @(negedge clk);
      check("ready_one_cycle", 64'(bus_ready), 64'd0);
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
    int            wt;
    logic          err;
    logic [DW-1:0] rdata;
    int            lat;
    logic [1:0]    st;
    logic [DW-1:0] data;
    int            pcyc;
  } vec_t;

  vec_t vecs [9];

  task automatic cfg_slave(input logic [AW-1:0] addr, input int wt,
                           input logic err, input logic [DW-1:0] rd);
    int idx;
    idx = int'(addr) / 64;
    if (idx < NS) begin
      wait_cyc[idx] = wt; err_cfg[idx] = err; rd_cfg[idx] = rd;
    end
  endtask

  task automatic cmp(input string tag, input int lat, input logic [1:0] st,
                     input logic [DW-1:0] d, input int pc,
                     input int elat, input logic [1:0] est,
                     input logic [DW-1:0] ed, input int epc);
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_status"}, 64'(st), 64'(est));
    check({tag, "_rdata"}, 64'(d), 64'(ed));
    check({tag, "_psel_cycles"}, 64'(pc), 64'(epc));
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pc, elat, epc;
    logic [1:0] st, est;
    logic [DW-1:0] d, ed;

    // Expected latency, status, data and psel cycle count for each vector.
    vecs[0] = '{8'h44, 1'b0, 32'h0,        4'h0, 0, 1'b0, 32'hCAFEF00D, 3, 2'b00, 32'hCAFEF00D, 2};
    vecs[1] = '{8'h08, 1'b1, 32'h12345678, 4'h5, 3, 1'b0, 32'h0,        6, 2'b00, 32'h0,        5};
    vecs[2] = '{8'hC0, 1'b0, 32'h0,        4'h0, 0, 1'b0, 32'h0,        1, 2'b11, 32'h0,        0};
    vecs[3] = '{8'h80, 1'b0, 32'h0,        4'h0, 9, 1'b0, 32'h77777777, 6, 2'b10, 32'h0,        5};
    vecs[4] = '{8'h10, 1'b0, 32'h0,        4'h0, 0, 1'b0, 32'h11112222, 3, 2'b00, 32'h11112222, 2};
    vecs[5] = '{8'h48, 1'b1, 32'hFFFF0000, 4'hF, 1, 1'b1, 32'h0,        4, 2'b10, 32'h0,        3};
    vecs[6] = '{8'h4C, 1'b0, 32'h0,        4'h0, 0, 1'b1, 32'hA5A5A5A5, 3, 2'b10, 32'hA5A5A5A5, 2};
    vecs[7] = '{8'hFF, 1'b1, 32'h1,        4'h1, 0, 1'b0, 32'h0,        1, 2'b11, 32'h0,        0};
    vecs[8] = '{8'h90, 1'b1, 32'hBEEF,     4'h3, 4, 1'b0, 32'h0,        6, 2'b10, 32'h0,        5};

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_psel", 64'(psel), 64'd0);
    check("rst_penable", 64'(penable), 64'd0);
    check("rst_ready", 64'(bus_ready), 64'd0);
    check("rst_status", 64'(bus_status), 64'd0);
    check("rst_rdata", 64'(bus_rdata), 64'd0);
    check("rst_paddr_pstrb_pwdata_pwrite", {pwdata, 16'h0, paddr, 3'b0, pwrite, pstrb}, 64'd0);
    check("pprot_const", 64'(pprot), 64'd2);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      cfg_slave(vecs[i].addr, vecs[i].wt, vecs[i].err, vecs[i].rdata);
      do_txn(vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, 1'b0, lat, st, d, pc);
      cmp($sformatf("vec%0d", i), lat, st, d, pc, vecs[i].lat, vecs[i].st, vecs[i].data, vecs[i].pcyc);
    end

    // Back-to-back: valid stays high through RESPOND
    cfg_slave(8'h40, 0, 1'b1, 32'h13579BDF);
    do_txn(8'h40, 1'b0, 32'h0, 4'h0, 1'b1, lat, st, d, pc);
    cmp("b2b_first", lat, st, d, pc, 3, 2'b10, 32'h13579BDF, 2);
    cfg_slave(8'h00, 0, 1'b0, 32'h600DD00D);
    bus_addr = 8'h00; bus_access = 2'b00;
    @(negedge clk);
    check("b2b_idle_psel", 64'(psel), 64'd0);
    check("b2b_idle_ready", 64'(bus_ready), 64'd0);
    do_txn(8'h00, 1'b0, 32'h0, 4'h0, 1'b0, lat, st, d, pc);
    cmp("b2b_second", lat, st, d, pc, 3, 2'b00, 32'h600DD00D, 2);

    // Reset in the middle of ACCESS
    cfg_slave(8'h04, 99, 1'b0, 32'h0);
    bus_valid = 1'b1; bus_access = 2'b01; bus_addr = 8'h04;
    bus_wdata = 32'hFACEFACE; bus_strb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_access", 64'(penable), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_psel_penable", {psel, penable}, 64'd0);
    check("arst_ready_status_rdata", {bus_ready, bus_status, bus_rdata}, 64'd0);
    check("arst_paddr_pwrite_pstrb", {paddr, pwrite, pstrb}, 64'd0);
    check("arst_pwdata", 64'(pwdata), 64'd0);
    bus_valid = 1'b0;
    @(negedge clk);
    check("rst_hold_ready", 64'(bus_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_slave(8'h04, 1, 1'b0, 32'h0BADCAFE);
    do_txn(8'h04, 1'b0, 32'h0, 4'h0, 1'b0, lat, st, d, pc);
    cmp("post_rst", lat, st, d, pc, 4, 2'b00, 32'h0BADCAFE, 3);

    // Randomized requests against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      logic wr, er;
      logic [DW-1:0] wd, rd;
      logic [3:0] sb;
      int wt;
      a  = AW'($urandom);
      wr = 1'($urandom);
      er = 1'($urandom);
      wd = $urandom;
      rd = $urandom;
      sb = 4'($urandom);
      wt = int'($urandom_range(0, 6));
      cfg_slave(a, wt, er, rd);
      model(a, wr, wt, er, rd, elat, est, ed, epc);
      do_txn(a, wr, wd, sb, 1'b0, lat, st, d, pc);
      cmp($sformatf("rnd%0d", i), lat, st, d, pc, elat, est, ed, epc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rggen_apb_multi_bridge.md
RGGEN_APB_MULTI_BRIDGE -- requirements
Module: rggen_apb_multi_bridge

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, the bus and APB address width in bits.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, the data width in bits; it is a multiple of 8.
REQ-003 SHALL have parameter SLAVES, default 2, the number of APB slave ports; range 1..16.
REQ-004 SHALL have parameter SLAVE_ADDRESS_WIDTH, default 6, the log2 of each slave window size; slave index = address[SLAVE_ADDRESS_WIDTH +: clog2(SLAVES)], with 0 index bits when SLAVES=1.
REQ-005 SHALL have parameter TIMEOUT, default 0, the maximum number of ACCESS cycles; 0 disables the timeout.
REQ-006 SHALL have parameter PPROT, default 3'b000, the constant value driven on o_pprot.
REQ-007 SHALL have these ports, one per line: name direction width meaning:
  i_clk  in  1  clock
  i_rst_n  in  1  reset; asynchronous, active-low
  i_bus_valid  in  1  request valid, held until o_bus_ready
  i_bus_access  in  2  bit0=1 write, bit0=0 read
  i_bus_address  in  ADDRESS_WIDTH  request address
  i_bus_write_data  in  BUS_WIDTH  write data
  i_bus_strobe  in  BUS_WIDTH/8  byte strobes
  o_bus_ready  out  1  one-cycle response strobe
  o_bus_status  out  2  00 OKAY, 10 SLVERR, 11 DECERR
  o_bus_read_data  out  BUS_WIDTH  read data, valid with o_bus_ready
  o_psel  out  SLAVES  one-hot select
  o_penable  out  1  APB enable
  o_paddr  out  ADDRESS_WIDTH  registered address
  o_pprot  out  3  tied to PPROT
  o_pwrite  out  1  registered write flag
  o_pstrb  out  BUS_WIDTH/8  registered strobes; all zero on reads
  o_pwdata  out  BUS_WIDTH  registered write data
  i_pready  in  SLAVES  per-slave ready
  i_prdata  in  SLAVES*BUS_WIDTH  per-slave read data; slave k occupies [k*BUS_WIDTH +: BUS_WIDTH]
  i_pslverr  in  SLAVES  per-slave error

Function
REQ-008 SHALL implement an FSM with states IDLE, SETUP, ACCESS and RESPOND.
REQ-009 In IDLE with i_bus_valid=1, SHALL latch address, access, write data and strobe; it SHALL go to SETUP if the slave index < SLAVES, else to RESPOND with DECERR.
REQ-010 In SETUP, SHALL assert o_psel[index] with o_penable=0 for exactly one cycle, then go to ACCESS.
REQ-011 In ACCESS, SHALL assert o_psel[index] and o_penable; it SHALL stay in ACCESS while i_pready[index]=0.
REQ-012 On i_pready[index]=1 in ACCESS, SHALL register i_prdata and i_pslverr of that slave and go to RESPOND; status SHALL be 10 if pslverr=1, else 00.
REQ-013 The APB address/control outputs SHALL remain stable from SETUP through the final ACCESS cycle.
REQ-014 When TIMEOUT>0, SHALL count ACCESS cycles; if cycle TIMEOUT completes without pready, it SHALL deassert psel/penable and go to RESPOND with SLVERR and read data 0.
REQ-015 A pready arriving in the same cycle as the timeout SHALL win, giving a normal completion.
REQ-016 In RESPOND, SHALL assert o_bus_ready for exactly one cycle with registered status and data, then go to IDLE.
REQ-017 i_bus_valid seen during RESPOND SHALL NOT start a transaction; a new transaction SHALL only be accepted from IDLE.
REQ-018 Minimum latency (request sampled at edge N, zero-wait slave) SHALL be o_bus_ready high in cycle N+3.
REQ-019 A DECERR response SHALL have o_bus_ready high in cycle N+1 with no psel asserted and read data 0.
REQ-020 o_bus_read_data SHALL be 0 for write transactions and whenever o_bus_ready=0.
REQ-021 At most one o_psel bit SHALL be high in any cycle.
REQ-022 i_pready, i_prdata and i_pslverr of unselected slaves SHALL be ignored.

Reset
REQ-023 On i_rst_n=0, the FSM SHALL go to IDLE immediately and asynchronously, including mid-transaction; the in-flight transfer is abandoned with no response.
REQ-024 Reset values SHALL be: o_psel=0, o_penable=0, o_bus_ready=0, o_bus_status=00, o_bus_read_data=0, o_paddr=0, o_pwrite=0, o_pstrb=0, o_pwdata=0, timeout counter 0.

Verification
REQ-025 SLAVES=2: read of addr 0x44 with slave1 pready=1, prdata=0xCAFEF00D -> psel=2'b10 for 2 cycles, ready at N+3, status 00, data 0xCAFEF00D.
REQ-026 Write of addr 0x08, data 0x12345678, strobe 4'b0101, slave0 holding pready=0 for 3 cycles -> pwdata/pstrb stable, ready at N+6, status 00.
REQ-027 SLAVES=3, address 0xC0 (index 3) -> no psel, ready at N+1, status 11, data 0.
REQ-028 TIMEOUT=4, slave never ready -> psel drops after 4 ACCESS cycles, status 10, data 0; a following request to slave0 completes normally.
REQ-029 Slave pslverr=1 with pready -> status 10; back-to-back i_bus_valid -> the second request starts only after IDLE, with no psel during RESPOND.
REQ-030 Reset asserted during ACCESS -> all outputs return to REQ-024 values asynchronously; after reset release, a new request completes normally.
